// File: rtl/imm_decode_stage_if.sv
// Bus bundle for the immediate decode stage: instruction input handshake and decoded-field output handshake.
// A transfer on either side happens at a rising clk edge where valid and ready are both high; a producer holds valid and data until that edge.
interface imm_decode_stage_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int IMM_WIDTH   = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   out_valid;
  logic                   out_ready;
  logic [5:0]             out_opcode;
  logic [4:0]             out_rs;
  logic [4:0]             out_rt;
  logic [IMM_WIDTH-1:0]   out_imm;
  logic                   out_is_signed;
  logic                   out_has_imm;
  logic                   out_illegal;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_imm,
           out_is_signed, out_has_imm, out_illegal
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, out_opcode, out_rs, out_rt, out_imm,
           out_is_signed, out_has_imm, out_illegal
  );
endinterface

// File: rtl/imm_decode_stage.sv
// MIPS immediate-field decode stage: decodes on entry, then holds entries in a 2-deep skid buffer
// (OUT + SKID) so in_ready can come straight from a register.
module imm_decode_stage #(
  parameter int INSTR_WIDTH = 32,
  parameter int IMM_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  imm_decode_stage_if.slave   bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0]           opcode;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [IMM_WIDTH-1:0] imm;
    logic                 is_signed;
    logic                 has_imm;
    logic                 illegal;
  } entry_t;

  function automatic entry_t decode(input logic [INSTR_WIDTH-1:0] w);
    entry_t e;
    e.opcode    = w[31:26];
    e.rs        = w[25:21];
    e.rt        = w[20:16];
    e.imm       = w[IMM_WIDTH-1:0];
    e.is_signed = 1'b0;
    e.has_imm   = 1'b0;
    e.illegal   = 1'b0;
    case (w[31:26]) inside
      [6'h04:6'h0B], [6'h20:6'h25], [6'h28:6'h2B]: begin
        e.is_signed = 1'b1;
        e.has_imm   = 1'b1;
      end
      [6'h0C:6'h0F]:        e.has_imm = 1'b1;
      6'h00, 6'h02, 6'h03:  e.illegal = 1'b0;
      default:              e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  state_t r_state;
  state_t w_state_nxt;
  logic   r_in_ready;
  entry_t r_out;
  entry_t r_skid;
  entry_t w_dec;
  logic   w_in_fire;
  logic   w_out_fire;
  logic   w_load_out;
  logic   w_out_from_skid;
  logic   w_load_skid;

  assign w_dec      = decode(bus.instr);
  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = (r_state != S_EMPTY) & bus.out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_load_out      = 1'b0;
    w_out_from_skid = 1'b0;
    w_load_skid     = 1'b0;
    // Flush beats both handshakes; an output transfer in the same cycle is simply gone.
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = S_ONE;
            w_load_out  = 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_out = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = S_TWO;
            w_load_skid = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_out_fire) begin
            w_state_nxt     = S_ONE;
            w_load_out      = 1'b1;
            w_out_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_out      <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_TWO);
      if (w_load_out) begin
        r_out <= w_out_from_skid ? r_skid : w_dec;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = (r_state != S_EMPTY);
  assign bus.out_opcode    = r_out.opcode;
  assign bus.out_rs        = r_out.rs;
  assign bus.out_rt        = r_out.rt;
  assign bus.out_imm       = r_out.imm;
  assign bus.out_is_signed = r_out.is_signed;
  assign bus.out_has_imm   = r_out.has_imm;
  assign bus.out_illegal   = r_out.illegal;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: driver pushes hand-computed decodes into exp_q,
// a negedge monitor pops and compares on every output transfer.
module tb_imm_decode_stage;

  localparam int EW = 35;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] dbg_state;

  imm_decode_stage_if bus ();

  imm_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] ent(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm,
                                        input logic s, input logic h, input logic il);
    return {op, rs, rt, imm, s, h, il};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  logic [EW-1:0] act_ent;
  assign act_ent = {bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_imm,
                    bus.out_is_signed, bus.out_has_imm, bus.out_illegal};

  // Monitor: pop on every output transfer; also check that stalled outputs stay put.
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_ent   = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && bus.out_valid) chk("stall_stable", act_ent, prev_ent);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h expected=none at %0t", act_ent, $time);
        end else begin
          chk("out_entry", act_ent, exp_q.pop_front());
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_ent   = act_ent;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic [31:0] w, input logic [EW-1:0] e);
    int n;
    bus.in_valid = 1'b1;
    bus.instr    = w;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept instr=%h", w);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  logic [31:0]   vec_instr[16];
  logic [EW-1:0] vec_exp[16];

  initial begin
    vec_instr[0]  = 32'h2008FFFC; vec_exp[0]  = ent(6'h08, 5'd0,  5'd8,  16'hFFFC, 1, 1, 0);
    vec_instr[1]  = 32'h35088000; vec_exp[1]  = ent(6'h0D, 5'd8,  5'd8,  16'h8000, 0, 1, 0);
    vec_instr[2]  = 32'hFC000000; vec_exp[2]  = ent(6'h3F, 5'd0,  5'd0,  16'h0000, 0, 0, 1);
    vec_instr[3]  = 32'h00221820; vec_exp[3]  = ent(6'h00, 5'd1,  5'd2,  16'h1820, 0, 0, 0);
    vec_instr[4]  = 32'h8C220004; vec_exp[4]  = ent(6'h23, 5'd1,  5'd2,  16'h0004, 1, 1, 0);
    vec_instr[5]  = 32'h3C011234; vec_exp[5]  = ent(6'h0F, 5'd0,  5'd1,  16'h1234, 0, 1, 0);
    vec_instr[6]  = 32'h08000010; vec_exp[6]  = ent(6'h02, 5'd0,  5'd0,  16'h0010, 0, 0, 0);
    vec_instr[7]  = 32'h7C00ABCD; vec_exp[7]  = ent(6'h1F, 5'd0,  5'd0,  16'hABCD, 0, 0, 1);
    vec_instr[8]  = 32'h0C000000; vec_exp[8]  = ent(6'h03, 5'd0,  5'd0,  16'h0000, 0, 0, 0);
    vec_instr[9]  = 32'h10220003; vec_exp[9]  = ent(6'h04, 5'd1,  5'd2,  16'h0003, 1, 1, 0);
    vec_instr[10] = 32'hAFBF0014; vec_exp[10] = ent(6'h2B, 5'd29, 5'd31, 16'h0014, 1, 1, 0);
    vec_instr[11] = 32'h30000000; vec_exp[11] = ent(6'h0C, 5'd0,  5'd0,  16'h0000, 0, 1, 0);
    vec_instr[12] = 32'h40000000; vec_exp[12] = ent(6'h10, 5'd0,  5'd0,  16'h0000, 0, 0, 1);
    vec_instr[13] = 32'hB0000000; vec_exp[13] = ent(6'h2C, 5'd0,  5'd0,  16'h0000, 0, 0, 1);
    vec_instr[14] = 32'h98000000; vec_exp[14] = ent(6'h26, 5'd0,  5'd0,  16'h0000, 0, 0, 1);
    vec_instr[15] = 32'h94000000; vec_exp[15] = ent(6'h25, 5'd0,  5'd0,  16'h0000, 1, 1, 0);
  end

  initial begin
    int n;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_fields",    act_ent,       0);
    chk("rst_state",     dbg_state,     0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Single word, 1-cycle latency.
    bus.out_ready = 1'b1;
    send(vec_instr[0], vec_exp[0]);
    chk("latency_first", bus.out_valid, 1);
    idle(2);

    // Streaming directed vectors.
    for (int i = 1; i < 16; i++) send(vec_instr[i], vec_exp[i]);
    idle(3);
    chk("drain_empty", bus.out_valid, 0);

    // Backpressure: A and B fill both entries, C is held off.
    bus.out_ready = 1'b0;
    send(32'h2401AAAA, ent(6'h09, 5'd0, 5'd1, 16'hAAAA, 1, 1, 0));
    send(32'h3402BBBB, ent(6'h0D, 5'd0, 5'd2, 16'hBBBB, 0, 1, 0));
    bus.in_valid = 1'b1;
    bus.instr    = 32'h8C43CCCC;
    chk("bp_in_ready_low", bus.in_ready, 0);
    chk("bp_state_two",    dbg_state,    2);
    idle(3);
    chk("bp_still_low",    bus.in_ready, 0);
    chk("bp_out_is_a",     bus.out_imm,  16'hAAAA);
    bus.out_ready = 1'b1;
    fork
      send(32'h8C43CCCC, ent(6'h23, 5'd2, 5'd3, 16'hCCCC, 1, 1, 0));
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_no_gap", bus.out_valid, 1);
        end
      end
    join
    idle(3);

    // Flush in TWO with a word offered: everything discarded.
    bus.out_ready = 1'b0;
    send(32'h20040001, ent(6'h08, 5'd0, 5'd4, 16'h0001, 1, 1, 0));
    send(32'h20050002, ent(6'h08, 5'd0, 5'd5, 16'h0002, 1, 1, 0));
    bus.in_valid = 1'b1;
    bus.instr    = 32'h20060003;
    flush        = 1'b1;
    exp_q.delete();
    idle(1);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush2_out_valid", bus.out_valid, 0);
    chk("flush2_in_ready",  bus.in_ready,  1);
    chk("flush2_state",     dbg_state,     0);

    // Flush in ONE against an accepted word: that word is dropped too.
    send(32'h20070004, ent(6'h08, 5'd0, 5'd7, 16'h0004, 1, 1, 0));
    bus.in_valid = 1'b1;
    bus.instr    = 32'h20080005;
    flush        = 1'b1;
    exp_q.delete();
    idle(1);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush1_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    idle(4);

    // Async reset pulsed mid-cycle while holding one entry.
    bus.out_ready = 1'b0;
    send(32'h2009DEAD, ent(6'h08, 5'd0, 5'd9, 16'hDEAD, 1, 1, 0));
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_in_ready",  bus.in_ready,  1);
    chk("arst_imm_zero",  bus.out_imm,   0);
    exp_q.delete();
    #1;
    rst = 1'b0;
    idle(1);
    chk("arst_no_output", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    send(32'h280A0123, ent(6'h0A, 5'd0, 5'd10, 16'h0123, 1, 1, 0));
    chk("arst_latency", bus.out_valid, 1);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
    end
    idle(3);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter INSTR_WIDTH, default 32, instruction word width; only 32 is supported.
REQ-002 Parameter IMM_WIDTH, default 16, immediate field width; it matches the downstream sign extender input width.
REQ-003 Port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit, reset; asynchronous and active-high.
REQ-005 Port flush, input, 1 bit, synchronous discard of all held entries.
REQ-006 Port in_valid, input, 1 bit, instr holds a valid word.
REQ-007 Port in_ready, output, 1 bit, block accepts instr this cycle; driven directly from a register.
REQ-008 Port instr, input, INSTR_WIDTH bits, MIPS instruction word.
REQ-009 Port out_valid, output, 1 bit, decoded fields are valid.
REQ-010 Port out_ready, input, 1 bit, downstream accepts this cycle.
REQ-011 Port out_opcode, output, 6 bits, instr[31:26].
REQ-012 Port out_rs, output, 5 bits, instr[25:21].
REQ-013 Port out_rt, output, 5 bits, instr[20:16].
REQ-014 Port out_imm, output, IMM_WIDTH bits, instr[15:0]; feeds the sign extender dataIn.
REQ-015 Port out_is_signed, output, 1 bit, immediate requires sign extension; feeds the sign extender is_signed input.
REQ-016 Port out_has_imm, output, 1 bit, opcode uses the immediate field.
REQ-017 Port out_illegal, output, 1 bit, opcode not in the supported set.

Function
REQ-018 An input transfer SHALL occur when in_valid and in_ready are both high at a rising edge; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-019 Latency from input transfer to out_valid SHALL be exactly 1 cycle when the output register is empty or being drained that cycle.
REQ-020 Storage SHALL be a 2-entry skid buffer: output register (OUT) plus skid register (SKID).
REQ-021 Occupancy states SHALL be EMPTY (OUT and SKID empty), ONE (OUT full, SKID empty), and TWO (OUT and SKID full); in_ready SHALL be high exactly in EMPTY and ONE.
REQ-022 EMPTY plus input transfer SHALL go to ONE, with OUT loaded from instr.
REQ-023 ONE with input transfer and output transfer SHALL stay in ONE, with OUT reloaded from instr.
REQ-024 ONE with input transfer and no output transfer SHALL go to TWO, with SKID loaded from instr and OUT unchanged.
REQ-025 ONE with output transfer and no input transfer SHALL go to EMPTY.
REQ-026 TWO with output transfer SHALL go to ONE, with OUT loaded from SKID; TWO without output transfer SHALL hold.
REQ-027 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated.
REQ-028 Decode SHALL occur before the register write, and OUT, SKID and the outputs SHALL hold decoded fields.
REQ-029 Opcodes 0x04–0x0B, 0x20–0x25 and 0x28–0x2B SHALL decode as has_imm=1, is_signed=1.
REQ-030 Opcodes 0x0C–0x0F (ANDI, ORI, XORI, LUI) SHALL decode as has_imm=1, is_signed=0.
REQ-031 Opcodes 0x00, 0x02 and 0x03 SHALL decode as has_imm=0, is_signed=0, illegal=0.
REQ-032 All other opcodes SHALL decode as has_imm=0, is_signed=0, illegal=1.
REQ-033 out_imm SHALL always equal instr[15:0] of the held entry, regardless of has_imm.
REQ-034 flush SHALL empty OUT and SKID at the next edge and force in_ready=1.
REQ-035 flush SHALL take priority over a simultaneous input transfer, and the accepted word SHALL be discarded.
REQ-036 flush SHALL take priority over a simultaneous output transfer; that output transfer still counts as consumed downstream.
REQ-037 While out_valid=1 and out_ready=0, all out_* fields SHALL be stable.
REQ-038 With out_valid=0, the out_* data fields SHALL hold their last value.

Reset
REQ-039 While rst=1: out_valid=0, all out_* data fields=0, in_ready=1, and the state SHALL be EMPTY, taking effect immediately without waiting for a clock edge.
REQ-040 rst asserted mid-transfer SHALL discard OUT and SKID, and no transfer SHALL be reported in the cycle of deassertion.

Verification
REQ-041 The bench SHALL cover: instr=0x2008FFFC accepted with out_ready=1 -> next cycle out_valid=1, opcode=0x08, rs=0, rt=8, imm=0xFFFC, is_signed=1, has_imm=1, illegal=0.
REQ-042 The bench SHALL cover: instr=0x35088000 -> opcode=0x0D, rs=8, rt=8, imm=0x8000, is_signed=0, has_imm=1.
REQ-043 The bench SHALL cover: out_ready=0, three back-to-back words A, B, C offered -> A and B accepted, in_ready=0 from the cycle after B, C held off; raise out_ready -> outputs A, B, C in order, no gaps after the first.
REQ-044 The bench SHALL cover: state TWO with flush=1 and in_valid=1 the same cycle -> next cycle out_valid=0, in_ready=1, and the flushed word never appears.
REQ-045 The bench SHALL cover: opcode 0x3F and opcode 0x00 -> illegal=1, has_imm=0 for 0x3F; illegal=0, has_imm=0 for 0x00.
REQ-046 The bench SHALL cover: rst pulsed between clock edges while state is ONE -> out_valid drops to 0 immediately, in_ready=1, and the first word after release emerges with 1-cycle latency.
